// File: rtl/gcd_job_arbiter.sv
// Round-robin sequencer sharing one GCD engine between NUM_REQ requesters.
// Issues the start pulse, times the job and aborts it on watchdog expiry.
module gcd_job_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 4095
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [NUM_REQ-1:0]      REQ,
    input  logic [12*NUM_REQ-1:0]   REQ_OPCODE,
    input  logic [NUM_REQ-1:0]      REQ_CONSTANT_TIME,
    output logic [NUM_REQ-1:0]      GRANT,
    output logic [NUM_REQ-1:0]      ACK,
    output logic [NUM_REQ-1:0]      ERR,
    output logic [11:0]             CYCLE_COUNT,
    output logic                    BUSY,
    output logic                    ENG_START,
    output logic [11:0]             ENG_OPCODE,
    output logic                    ENG_CONSTANT_TIME,
    input  logic                    ENG_DONE,
    output logic                    ENG_ABORT
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   win_q, win_d;
    logic [11:0]     cnt_q, cnt_d;
    logic [11:0]     cyc_q, cyc_d;
    logic [11:0]     op_q, op_d;
    logic            ct_q, ct_d;
    logic            err_q, err_d;

    logic [IW-1:0]   pick_idx;
    logic            pick_vld;
    logic [12:0]     cnt_inc;
    logic [NUM_REQ-1:0] win_oh;
    int              j;

    // Walk downward so the closest requester after last_q is assigned last.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = last_q;
        j        = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = (int'(last_q) + k) % NUM_REQ;
            if (REQ[IW'(j)]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(j);
            end
        end
    end

    assign cnt_inc = {1'b0, cnt_q} + 13'd1;
    assign win_oh  = NUM_REQ'(1) << win_q;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        op_d    = op_q;
        ct_d    = ct_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    win_d   = pick_idx;
                    last_d  = pick_idx;
                    op_d    = REQ_OPCODE[12*int'(pick_idx) +: 12];
                    ct_d    = REQ_CONSTANT_TIME[pick_idx];
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_inc[11:0];
                // Done takes priority over a watchdog expiry in the same cycle.
                if (ENG_DONE) begin
                    cyc_d   = cnt_inc[11:0];
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_inc == 13'(TIMEOUT)) begin
                    cyc_d   = 12'(TIMEOUT);
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            last_q  <= IW'(NUM_REQ - 1);
            win_q   <= '0;
            cnt_q   <= '0;
            cyc_q   <= '0;
            op_q    <= '0;
            ct_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            op_q    <= op_d;
            ct_q    <= ct_d;
            err_q   <= err_d;
        end
    end

    assign BUSY              = (state_q != S_IDLE);
    assign GRANT             = BUSY ? win_oh : '0;
    assign ACK               = (state_q == S_DONE) ? win_oh : '0;
    assign ERR               = (state_q == S_DONE && err_q) ? win_oh : '0;
    assign ENG_START         = (state_q == S_START);
    assign ENG_ABORT         = (state_q == S_DONE) && err_q;
    assign ENG_OPCODE        = op_q;
    assign ENG_CONSTANT_TIME = ct_q;
    assign CYCLE_COUNT       = cyc_q;

endmodule

// File: tb/tb_gcd_job_arbiter.sv
// Directed bench for gcd_job_arbiter with NUM_REQ=2, TIMEOUT=16.
module tb_gcd_job_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [23:0] opcode;
    logic [1:0]  ct;
    logic        eng_done;
    logic [1:0]  grant, ack, err;
    logic [11:0] cycle_count, eng_opcode;
    logic        busy, eng_start, eng_ct, eng_abort;

    int checks = 0;
    int errors = 0;

    gcd_job_arbiter #(.NUM_REQ(2), .TIMEOUT(16)) dut (
        .CLK               (clk),
        .RESET             (reset),
        .REQ               (req),
        .REQ_OPCODE        (opcode),
        .REQ_CONSTANT_TIME (ct),
        .GRANT             (grant),
        .ACK               (ack),
        .ERR               (err),
        .CYCLE_COUNT       (cycle_count),
        .BUSY              (busy),
        .ENG_START         (eng_start),
        .ENG_OPCODE        (eng_opcode),
        .ENG_CONSTANT_TIME (eng_ct),
        .ENG_DONE          (eng_done),
        .ENG_ABORT         (eng_abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_ack"}, 32'(ack), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_start"}, 32'(eng_start), 0);
        chk({tag, "_abort"}, 32'(eng_abort), 0);
    endtask

    // n RUN cycles with no ack, ENG_DONE in the n-th, then step into DONE
    task automatic run_done(input string tag, input int n, input logic [1:0] g);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, "_run_grant"}, 32'(grant), 32'(g));
            chk({tag, "_run_ack"}, 32'(ack), 0);
            chk({tag, "_run_start"}, 32'(eng_start), 0);
        end
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
    endtask

    always @(negedge clk) begin
        chk("grant_onehot0", 32'($onehot0(grant)), 1);
        chk("ack_in_grant", 32'(ack & ~grant), 0);
        chk("err_in_ack", 32'(err & ~ack), 0);
    end

    initial begin
        reset    = 1'b1;
        req      = 2'b00;
        opcode   = '0;
        ct       = 2'b00;
        eng_done = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk_idle("rst");
        chk("rst_opcode", 32'(eng_opcode), 0);
        chk("rst_ct", 32'(eng_ct), 0);
        chk("rst_cyc", 32'(cycle_count), 0);

        req          = 2'b01;
        opcode[11:0] = 12'h0A5;
        ct           = 2'b01;
        tick();
        chk("j1_grant", 32'(grant), 1);
        chk("j1_start", 32'(eng_start), 1);
        chk("j1_busy", 32'(busy), 1);
        chk("j1_opcode", 32'(eng_opcode), 32'h0A5);
        chk("j1_ct", 32'(eng_ct), 1);
        opcode[11:0] = 12'h123;
        ct           = 2'b00;
        run_done("j1", 10, 2'b01);
        chk("j1_ack", 32'(ack), 1);
        chk("j1_err", 32'(err), 0);
        chk("j1_abort", 32'(eng_abort), 0);
        chk("j1_cyc", 32'(cycle_count), 10);
        chk("j1_opcode_hold", 32'(eng_opcode), 32'h0A5);
        req = 2'b00;
        tick();
        chk_idle("j1_end");
        chk("j1_cyc_hold", 32'(cycle_count), 10);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        req   = 2'b11;
        tick();
        chk("rr1_grant", 32'(grant), 1);
        run_done("rr1", 5, 2'b01);
        chk("rr1_ack", 32'(ack), 1);
        chk("rr1_cyc", 32'(cycle_count), 5);
        tick();
        chk_idle("rr1_gap");
        tick();
        chk("rr2_grant", 32'(grant), 2);
        chk("rr2_start", 32'(eng_start), 1);
        run_done("rr2", 5, 2'b10);
        chk("rr2_ack", 32'(ack), 2);
        tick();
        chk_idle("rr2_gap");
        tick();
        chk("rr3_grant", 32'(grant), 1);
        run_done("rr3", 5, 2'b01);
        chk("rr3_ack", 32'(ack), 1);
        req = 2'b00;
        tick();
        chk_idle("rr3_end");

        req = 2'b01;
        tick();
        chk("to_start", 32'(eng_start), 1);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("to_run_abort", 32'(eng_abort), 0);
            chk("to_run_ack", 32'(ack), 0);
        end
        tick();
        chk("to_abort", 32'(eng_abort), 1);
        chk("to_ack", 32'(ack), 1);
        chk("to_err", 32'(err), 1);
        chk("to_cyc", 32'(cycle_count), 16);
        req = 2'b00;
        tick();
        chk_idle("to_end");

        req = 2'b01;
        tick();
        chk("col_grant", 32'(grant), 1);
        run_done("col", 16, 2'b01);
        chk("col_ack", 32'(ack), 1);
        chk("col_err", 32'(err), 0);
        chk("col_abort", 32'(eng_abort), 0);
        chk("col_cyc", 32'(cycle_count), 16);
        req = 2'b00;
        tick();
        chk_idle("col_end");

        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk_idle("sp_idle");
        req = 2'b10;
        tick();
        chk("sp_grant", 32'(grant), 2);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("sp_start_ack", 32'(ack), 0);
        chk("sp_start_busy", 32'(busy), 1);
        tick();
        req = 2'b00;
        tick();
        tick();
        chk("drop_grant", 32'(grant), 2);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("drop_ack", 32'(ack), 2);
        chk("drop_cyc", 32'(cycle_count), 4);
        tick();
        chk_idle("drop_end");

        req = 2'b01;
        tick();
        chk("mr_grant", 32'(grant), 1);
        tick();
        tick();
        reset = 1'b1;
        req   = 2'b11;
        tick();
        chk_idle("mr_rst");
        chk("mr_opcode", 32'(eng_opcode), 0);
        chk("mr_cyc", 32'(cycle_count), 0);
        reset = 1'b0;
        tick();
        chk("mr_first_grant", 32'(grant), 1);
        chk("mr_first_start", 32'(eng_start), 1);
        req = 2'b00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
